// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: generic pipeline-stage register with a valid/ready handshake.
// It holds at most two entries: a main entry that drives the outputs, and a
// skid entry that absorbs the one extra accept possible after out_ready drops.
// The stage also supports a synchronous flush and keeps a saturating bubble count.
// The control field is masked to zero whenever the stage holds no valid entry,
// so a bubble can never trigger a register or memory write further down.
module pipe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 16,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [CNT_W-1:0]  bubble_count
);

  localparam logic [CNT_W-1:0] cntMax = {CNT_W{1'b1}};

  logic              mainV;
  logic [DATA_W-1:0] mainD;
  logic [CTRL_W-1:0] mainC;
  logic              skidV;
  logic [DATA_W-1:0] skidD;
  logic [CTRL_W-1:0] skidC;
  logic [CNT_W-1:0]  bubbleCnt;
  logic              inFire;
  logic              outFire;

  // Handshake terms. in_ready comes straight from a flop, so it depends only
  // on whether the skid entry is occupied.
  always_comb begin
    in_ready  = !skidV;
    inFire    = in_valid && !skidV;
    outFire   = mainV && out_ready;
    out_valid = mainV;
    out_data  = mainD;
    out_ctrl  = mainV ? mainC : '0;
  end

  assign bubble_count = bubbleCnt;

  // Entry storage. A flush kills both entries and leaves the data untouched.
  // When main is free it refills from skid first, which keeps FIFO order.
  // An input accepted while main is stuck goes into skid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mainV <= 1'b0;
      mainD <= '0;
      mainC <= '0;
      skidV <= 1'b0;
      skidD <= '0;
      skidC <= '0;
    end else if (flush) begin
      mainV <= 1'b0;
      skidV <= 1'b0;
    end else if (!mainV || outFire) begin
      if (skidV) begin
        mainV <= 1'b1;
        mainD <= skidD;
        mainC <= skidC;
        skidV <= 1'b0;
      end else if (inFire) begin
        mainV <= 1'b1;
        mainD <= in_data;
        mainC <= in_ctrl;
      end else begin
        mainV <= 1'b0;
      end
    end else if (inFire) begin
      skidV <= 1'b1;
      skidD <= in_data;
      skidC <= in_ctrl;
    end
  end

  // Bubble counter. It counts edges where downstream was ready but nothing was
  // offered. Flush edges are not counted. The count saturates instead of wrapping.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubbleCnt <= '0;
    end else if (out_ready && !mainV && !flush && (bubbleCnt != cntMax)) begin
      bubbleCnt <= bubbleCnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed self-checking bench for pipe_stage_reg.
// A second instance with a 3-bit counter exercises bubble_count saturation.
module tb_pipe_stage_reg;

  logic        clk;
  logic        reset;
  logic        flush;
  logic        inValid;
  logic        inReady;
  logic [31:0] inData;
  logic [15:0] inCtrl;
  logic        outValid;
  logic        outReady;
  logic [31:0] outData;
  logic [15:0] outCtrl;
  logic [15:0] bubbleCount;

  logic        inReady2;
  logic        outValid2;
  logic [31:0] outData2;
  logic [15:0] outCtrl2;
  logic [2:0]  bubbleCount2;

  int assertCount;
  int failCount;

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(inValid), .in_ready(inReady), .in_data(inData), .in_ctrl(inCtrl),
    .out_valid(outValid), .out_ready(outReady), .out_data(outData),
    .out_ctrl(outCtrl), .bubble_count(bubbleCount)
  );

  pipe_stage_reg #(.DATA_W(32), .CTRL_W(16), .CNT_W(3)) dutSat (
    .clk(clk), .reset(reset), .flush(1'b0),
    .in_valid(1'b0), .in_ready(inReady2), .in_data(32'h0), .in_ctrl(16'h0),
    .out_valid(outValid2), .out_ready(1'b1), .out_data(outData2),
    .out_ctrl(outCtrl2), .bubble_count(bubbleCount2)
  );

  // Free-running clock with a 10-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] d,
                               input logic [15:0] c, input logic rdy,
                               input logic fl);
    inValid  = v;
    inData   = d;
    inCtrl   = c;
    outReady = rdy;
    flush    = fl;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b0;
    #2;
    reset = 1'b1;
  endtask

  // Directed test sequence.
  initial begin
    assertCount = 0;
    failCount   = 0;
    reset = 1'b0;
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    #2;
    checkOutput("rstInReady", 64'(inReady), 64'd1);
    checkOutput("rstOutValid", 64'(outValid), 64'd0);
    checkOutput("rstOutData", 64'(outData), 64'd0);
    checkOutput("rstOutCtrl", 64'(outCtrl), 64'd0);
    checkOutput("rstBubble", 64'(bubbleCount), 64'd0);
    #10;
    reset = 1'b1;

    // The saturating counter instance counts bubbles from the first edge.
    repeat (3) step();
    checkOutput("satCount3", 64'(bubbleCount2), 64'd3);
    repeat (7) step();
    checkOutput("satCount7", 64'(bubbleCount2), 64'd7);
    repeat (3) step();
    checkOutput("satHold7", 64'(bubbleCount2), 64'd7);
    checkOutput("noBubbleWhenNotReady", 64'(bubbleCount), 64'd0);

    // Single entry into an empty stage appears after one cycle.
    doReset();
    applyStimulus(1'b1, 32'h4, 16'h5, 1'b1, 1'b0);
    checkOutput("t1InReadyBefore", 64'(inReady), 64'd1);
    step();
    checkOutput("t1OutValid", 64'(outValid), 64'd1);
    checkOutput("t1OutData", 64'(outData), 64'h4);
    checkOutput("t1OutCtrl", 64'(outCtrl), 64'h5);
    checkOutput("t1InReady", 64'(inReady), 64'd1);
    checkOutput("t1Bubble", 64'(bubbleCount), 64'd1);

    // Streaming at full throughput.
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'h10 + 32'(i), 16'h100 + 16'(i), 1'b1, 1'b0);
      step();
      checkOutput($sformatf("t2Data%0d", i), 64'(outData), 64'h10 + 64'(i));
      checkOutput($sformatf("t2Ctrl%0d", i), 64'(outCtrl), 64'h100 + 64'(i));
      checkOutput($sformatf("t2InReady%0d", i), 64'(inReady), 64'd1);
    end
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    step();
    checkOutput("t2DrainValid", 64'(outValid), 64'd0);
    checkOutput("t2DrainCtrlMasked", 64'(outCtrl), 64'd0);
    checkOutput("t2DataHolds", 64'(outData), 64'h13);
    checkOutput("t2Bubble", 64'(bubbleCount), 64'd1);

    // Backpressure fills skid, then drains in order.
    applyStimulus(1'b1, 32'hA, 16'hA, 1'b0, 1'b0);
    step();
    checkOutput("t3MainA", 64'(outData), 64'hA);
    checkOutput("t3InReadyA", 64'(inReady), 64'd1);
    applyStimulus(1'b1, 32'hB, 16'hB, 1'b0, 1'b0);
    step();
    checkOutput("t3HoldA", 64'(outData), 64'hA);
    checkOutput("t3InReadyLow", 64'(inReady), 64'd0);
    applyStimulus(1'b1, 32'hC, 16'hC, 1'b0, 1'b0);
    step();
    checkOutput("t3StillA", 64'(outCtrl), 64'hA);
    checkOutput("t3StillLow", 64'(inReady), 64'd0);
    applyStimulus(1'b1, 32'hC, 16'hC, 1'b1, 1'b0);
    step();
    checkOutput("t3OutB", 64'(outData), 64'hB);
    checkOutput("t3InReadyBack", 64'(inReady), 64'd1);
    step();
    checkOutput("t3OutC", 64'(outData), 64'hC);
    checkOutput("t3OutCValid", 64'(outValid), 64'd1);
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    step();
    checkOutput("t3Empty", 64'(outValid), 64'd0);
    checkOutput("t3Bubble", 64'(bubbleCount), 64'd1);

    // Flush with both entries full discards everything, including the input.
    applyStimulus(1'b1, 32'hA, 16'h3A, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'hB, 16'h3B, 1'b0, 1'b0);
    step();
    checkOutput("t4Full", 64'(inReady), 64'd0);
    applyStimulus(1'b1, 32'hD, 16'h3D, 1'b0, 1'b1);
    step();
    checkOutput("t4FlushValid", 64'(outValid), 64'd0);
    checkOutput("t4FlushCtrl", 64'(outCtrl), 64'd0);
    checkOutput("t4FlushInReady", 64'(inReady), 64'd1);
    checkOutput("t4DataKept", 64'(outData), 64'hA);
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b0);
    step();
    checkOutput("t4NoD", 64'(outValid), 64'd0);
    checkOutput("t4Bubble", 64'(bubbleCount), 64'd2);
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b1, 1'b1);
    step();
    checkOutput("t4FlushNoCount", 64'(bubbleCount), 64'd2);

    // An asynchronous reset while the stage is full clears it immediately.
    applyStimulus(1'b1, 32'h55, 16'h55, 1'b0, 1'b0);
    step();
    applyStimulus(1'b1, 32'h66, 16'h66, 1'b0, 1'b0);
    step();
    checkOutput("t6FullReady", 64'(inReady), 64'd0);
    checkOutput("t6FullValid", 64'(outValid), 64'd1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("t6AsyncValid", 64'(outValid), 64'd0);
    checkOutput("t6AsyncReady", 64'(inReady), 64'd1);
    checkOutput("t6AsyncBubble", 64'(bubbleCount), 64'd0);
    checkOutput("t6AsyncCtrl", 64'(outCtrl), 64'd0);
    checkOutput("t6AsyncData", 64'(outData), 64'd0);
    reset = 1'b1;
    applyStimulus(1'b0, 32'h0, 16'h0, 1'b0, 1'b0);
    step();
    checkOutput("t6PostEmpty", 64'(outValid), 64'd0);
    applyStimulus(1'b1, 32'h77, 16'h7, 1'b1, 1'b0);
    step();
    checkOutput("t6PostValid", 64'(outValid), 64'd1);
    checkOutput("t6PostData", 64'(outData), 64'h77);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, generic pipeline-stage register that replaces per-stage hand-built registers such as the fixed ID/EXE register.
- Adds a valid/ready handshake with a 2-entry skid buffer, synchronous flush (bubble insertion) and a saturating bubble counter.
- Carries an opaque data field and a control field. The control field is forced to zero whenever the stage holds no valid instruction, so that regWrite and memWrite can never fire on a bubble.
- Instantiated between any two pipeline stages (IF/ID, ID/EXE, EXE/MEM, MEM/WB).

Parameters:
- DATA_W, 32, width of the datapath payload (PC+4, register operands, immediate, register numbers, concatenated).
- CTRL_W, 16, width of the control payload (aluOp, aluSrc, regWrite, memWrite, ...); must be >= 1.
- CNT_W, 16, width of bubble_count.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset (0 = reset)
- flush  in  1  synchronous kill of all held entries
- in_valid  in  1  upstream offers an entry
- in_ready  out  1  stage can accept; registered, depends only on skid occupancy
- in_data  in  DATA_W  upstream data payload
- in_ctrl  in  CTRL_W  upstream control payload
- out_valid  out  1  main entry valid
- out_ready  in  1  downstream accepts
- out_data  out  DATA_W  main entry data
- out_ctrl  out  CTRL_W  main entry control; all-zero when out_valid=0
- bubble_count  out  CNT_W  cycles with out_ready=1 and out_valid=0, saturating

Behaviour:
- Storage: main entry {main_v, main_d, main_c} drives the outputs; skid entry {skid_v, skid_d, skid_c}.
- Reset (reset=0, asynchronous): main_v=0, skid_v=0, all data/control registers 0, bubble_count=0. Resulting outputs: in_ready=1, out_valid=0, out_data=0, out_ctrl=0.
- Handshake definitions:
  - in_ready = !skid_v.
  - in_fire = in_valid & in_ready.
  - out_fire = main_v & out_ready.
- Per-edge update, in priority order:
  1. flush=1: main_v<=0 and skid_v<=0. Any in_fire in that cycle is discarded. Data registers keep their values.
  2. Main empty or out_fire:
     - skid_v=1: main<=skid, skid_v<=0 (in_ready was 0, so no accept).
     - else if in_fire: main<=in, main_v<=1.
     - else: main_v<=0.
  3. Main full, no out_fire, in_fire: skid<=in, skid_v<=1.
  4. Otherwise: hold all.
- Latency: 1 cycle from in_fire into an empty stage to out_valid=1. Throughput: 1 entry/cycle under continuous out_ready=1.
- Ordering: strict FIFO. An entry in skid always leaves before any later input.
- Backpressure: after out_ready deasserts, at most one further entry is accepted (into skid); in_ready falls the following cycle. Occupancy never exceeds 2. Nothing is dropped or duplicated.
- out_ctrl = main_v ? main_c : 0 (combinational mask).
- out_data = main_d regardless of main_v; it holds its last value when invalid.
- bubble_count: +1 on each edge where out_ready=1, out_valid=0 and flush=0. Saturates at 2^CNT_W-1 (no wrap). Cleared only by reset.
- Reset asserted mid-transfer clears both entries immediately. The first edge after release behaves as an empty stage.
- in_data and in_ctrl are ignored when in_fire=0.

Test Plan:
1. Reset=0, then release; in_valid=1, in_data=0x00000004, in_ctrl=0x0005, out_ready=1 -> next edge: out_valid=1, out_data=0x00000004, out_ctrl=0x0005. in_ready stays 1 throughout.
2. Stream 0x10, 0x11, 0x12, 0x13 with out_ready held 1 -> outputs appear on 4 consecutive cycles in order. in_ready never drops. bubble_count increments only on the cycle before the first output.
3. Main holds 0xA. Drop out_ready and offer 0xB, then 0xC -> 0xB captured in skid, in_ready=0 the next cycle, 0xC is held off. Raise out_ready -> output sequence is 0xA, 0xB, 0xC with no loss.
4. Both entries full (0xA main, 0xB skid), assert flush=1 together with in_valid=1 and in_data=0xD -> next edge: out_valid=0, out_ctrl=0, in_ready=1. 0xD is never output.
5. CNT_W=3, out_ready=1, no input for 10 cycles -> bubble_count reaches 7 and holds at 7.
6. Stage full with the skid occupied, assert reset=0 between clock edges -> out_valid=0, in_ready=1 and bubble_count=0 immediately, without waiting for a clock edge.
